// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter and its init/refresh/write/read sequencers.
// master = arbiter side (drives grants and SDRAM pins), slave = sequencer side.
interface sdram_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2
);
  logic                 init_done;
  logic [3:0]           init_cmd;
  logic [ADDR_BITS-1:0] init_addr;

  logic                 aref_req;
  logic                 aref_done;
  logic [3:0]           aref_cmd;
  logic [ADDR_BITS-1:0] aref_addr;

  logic                 wr_req;
  logic                 wr_done_all;
  logic                 wr_go_aref;
  logic [3:0]           wr_cmd;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [BA_BITS-1:0]   wr_ba;

  logic                 rd_req;
  logic                 rd_done_all;
  logic                 rd_go_aref;
  logic [3:0]           rd_cmd;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [BA_BITS-1:0]   rd_ba;

  logic                 aref_en;
  logic                 wr_en;
  logic                 rd_en;
  logic [3:0]           sdram_cmd;
  logic [ADDR_BITS-1:0] sdram_addr;
  logic [BA_BITS-1:0]   sdram_ba;
  logic                 aref_late;
  logic [2:0]           arb_state;

  modport master (
    input  init_done, init_cmd, init_addr,
    input  aref_req, aref_done, aref_cmd, aref_addr,
    input  wr_req, wr_done_all, wr_go_aref, wr_cmd, wr_addr, wr_ba,
    input  rd_req, rd_done_all, rd_go_aref, rd_cmd, rd_addr, rd_ba,
    output aref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_ba, aref_late, arb_state
  );

  modport slave (
    output init_done, init_cmd, init_addr,
    output aref_req, aref_done, aref_cmd, aref_addr,
    output wr_req, wr_done_all, wr_go_aref, wr_cmd, wr_addr, wr_ba,
    output rd_req, rd_done_all, rd_go_aref, rd_cmd, rd_addr, rd_ba,
    input  aref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_ba, aref_late, arb_state
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: refresh > write > read, one grant per S_ARB pass.
// Define ARB_RR_EN to alternate write/read when both request in the same cycle.
module sdram_arbiter #(
  parameter int ADDR_BITS     = 12,
  parameter int BA_BITS       = 2,
  parameter int AREF_MAX_WAIT = 10,
  parameter int WAIT_BITS     = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  sdram_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARB   = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t               state_q, state_d;
  logic                 aref_en_q, wr_en_q, rd_en_q;
  logic                 aref_late_q;
  logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                 pick_wr;
  logic [3:0]           cmd_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [BA_BITS-1:0]   ba_d;

`ifdef ARB_RR_EN
  // 1 = read was served last, so the first write/read tie goes to write.
  logic last_rd_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_rd_q <= 1'b1;
    end else if (state_q == S_ARB && state_d == S_WRITE) begin
      last_rd_q <= 1'b0;
    end else if (state_q == S_ARB && state_d == S_READ) begin
      last_rd_q <= 1'b1;
    end
  end

  assign pick_wr = bus.wr_req && (!bus.rd_req || last_rd_q);
`else
  assign pick_wr = bus.wr_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (bus.init_done) state_d = S_ARB;
      S_ARB: begin
        if (bus.aref_req)    state_d = S_AREF;
        else if (pick_wr)    state_d = S_WRITE;
        else if (bus.rd_req) state_d = S_READ;
      end
      S_AREF:  if (bus.aref_done) state_d = S_ARB;
      S_WRITE: if (bus.wr_done_all || bus.wr_go_aref) state_d = S_ARB;
      S_READ:  if (bus.rd_done_all || bus.rd_go_aref) state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    case (state_q)
      S_INIT: begin
        cmd_d  = bus.init_cmd;
        addr_d = bus.init_addr;
      end
      S_AREF: begin
        cmd_d  = bus.aref_cmd;
        addr_d = bus.aref_addr;
      end
      S_WRITE: begin
        cmd_d  = bus.wr_cmd;
        addr_d = bus.wr_addr;
        ba_d   = bus.wr_ba;
      end
      S_READ: begin
        cmd_d  = bus.rd_cmd;
        addr_d = bus.rd_addr;
        ba_d   = bus.rd_ba;
      end
      default: ;
    endcase
  end

  // Starvation count: cleared when refresh is granted, saturates otherwise.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_ARB && state_d == S_AREF) begin
      wait_cnt_d = '0;
    end else if (bus.aref_req && state_q != S_AREF && wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      aref_en_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wait_cnt_q  <= '0;
      aref_late_q <= 1'b0;
    end else begin
      aref_en_q   <= (state_q == S_ARB) && (state_d == S_AREF);
      wr_en_q     <= (state_q == S_ARB) && (state_d == S_WRITE);
      rd_en_q     <= (state_q == S_ARB) && (state_d == S_READ);
      wait_cnt_q  <= wait_cnt_d;
      aref_late_q <= aref_late_q || (wait_cnt_d >= WAIT_BITS'(AREF_MAX_WAIT));
    end
  end

  assign bus.aref_en    = aref_en_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.sdram_cmd  = cmd_d;
  assign bus.sdram_addr = addr_d;
  assign bus.sdram_ba   = ba_d;
  assign bus.aref_late  = aref_late_q;
  assign bus.arb_state  = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: grant scoreboard plus per-scenario state checks.
module tb_sdram_arbiter;
  localparam int ADDR_BITS = 12;
  localparam int BA_BITS   = 2;
  localparam logic [3:0] NOP = 4'b0111;

  typedef enum int {G_AREF = 0, G_WR = 1, G_RD = 2} grant_e;
  typedef struct {
    grant_e               kind;
    logic [3:0]           cmd;
    logic [ADDR_BITS-1:0] addr;
    logic [BA_BITS-1:0]   ba;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  sdram_arbiter_if #(.ADDR_BITS(ADDR_BITS), .BA_BITS(BA_BITS)) bus ();

  sdram_arbiter #(
    .ADDR_BITS(ADDR_BITS), .BA_BITS(BA_BITS), .AREF_MAX_WAIT(10), .WAIT_BITS(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_grant(input grant_e k);
    exp_t e;
    e.kind = k;
    case (k)
      G_AREF: begin e.cmd = bus.aref_cmd; e.addr = bus.aref_addr; e.ba = '0; end
      G_WR:   begin e.cmd = bus.wr_cmd;   e.addr = bus.wr_addr;   e.ba = bus.wr_ba; end
      default: begin e.cmd = bus.rd_cmd;  e.addr = bus.rd_addr;   e.ba = bus.rd_ba; end
    endcase
    exp_q.push_back(e);
  endtask

  // Grant monitor: every grant pulse must match the next scoreboard entry.
  always @(negedge sys_clk) begin : grant_mon
    int     ng;
    grant_e obs;
    exp_t   e;
    ng = int'(bus.aref_en) + int'(bus.wr_en) + int'(bus.rd_en);
    if (ng != 0) begin
      n_vec++;
      obs = bus.aref_en ? G_AREF : (bus.wr_en ? G_WR : G_RD);
      if (ng > 1) begin
        n_err++;
        $display("FAIL grant_onehot: got aref_en=%b wr_en=%b rd_en=%b, want one grant",
                 bus.aref_en, bus.wr_en, bus.rd_en);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL grant_unexpected: got kind=%0d at %0t, want no grant", obs, $time);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.kind || bus.sdram_cmd !== e.cmd || bus.sdram_addr !== e.addr ||
            bus.sdram_ba !== e.ba) begin
          n_err++;
          $display("FAIL grant_bus: got kind=%0d cmd=%b addr=%h ba=%b, want kind=%0d cmd=%b addr=%h ba=%b",
                   obs, bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba, e.kind, e.cmd, e.addr, e.ba);
        end
      end
    end
  end

  task automatic test_reset();
    sys_rst = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.arb_state !== 3'd0 || {bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b000 ||
        bus.aref_late !== 1'b0 || bus.sdram_cmd !== bus.init_cmd ||
        bus.sdram_addr !== bus.init_addr || bus.sdram_ba !== 2'b00) begin
      n_err++;
      $display("FAIL reset_outputs: got state=%0d grants=%b late=%b cmd=%b addr=%h ba=%b, want 0 000 0 %b %h 00",
               bus.arb_state, {bus.aref_en, bus.wr_en, bus.rd_en}, bus.aref_late,
               bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba, bus.init_cmd, bus.init_addr);
    end
    sys_rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_vec++;
      if (bus.arb_state !== 3'd0 || bus.sdram_cmd !== bus.init_cmd) begin
        n_err++;
        $display("FAIL init_hold[%0d]: got state=%0d cmd=%b, want 0 %b",
                 c, bus.arb_state, bus.sdram_cmd, bus.init_cmd);
      end
    end
    bus.init_done = 1'b1;
    step();
    n_vec++;
    if (bus.arb_state !== 3'd1) begin
      n_err++;
      $display("FAIL init_exit: got state=%0d, want 1", bus.arb_state);
    end
    n_vec++;
    if (bus.sdram_cmd !== NOP || bus.sdram_addr !== 12'h000 || bus.sdram_ba !== 2'b00) begin
      n_err++;
      $display("FAIL arb_nop: got cmd=%b addr=%h ba=%b, want 0111 000 00",
               bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba);
    end
    step();
    n_vec++;
    if (bus.arb_state !== 3'd1) begin
      n_err++;
      $display("FAIL arb_idle: got state=%0d, want 1", bus.arb_state);
    end
  endtask

  task automatic test_tie();
    logic [2:0] want_second;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    expect_grant(G_WR);
    step();
    n_vec++;
    if (bus.arb_state !== 3'd3) begin
      n_err++;
      $display("FAIL tie_first: got state=%0d, want 3", bus.arb_state);
    end
    step();
    // Write job ends but another write is queued; read is still waiting.
    bus.wr_done_all = 1'b1;
`ifdef ARB_RR_EN
    expect_grant(G_RD);
    want_second = 3'd4;
`else
    expect_grant(G_WR);
    want_second = 3'd3;
`endif
    step();
    bus.wr_done_all = 1'b0;
    n_vec++;
    if (bus.arb_state !== 3'd1 || bus.sdram_cmd !== NOP) begin
      n_err++;
      $display("FAIL tie_gap: got state=%0d cmd=%b, want 1 0111", bus.arb_state, bus.sdram_cmd);
    end
    step();
    n_vec++;
    if (bus.arb_state !== want_second) begin
      n_err++;
      $display("FAIL tie_second: got state=%0d, want %0d", bus.arb_state, want_second);
    end
    step();
`ifdef ARB_RR_EN
    bus.rd_done_all = 1'b1;
    bus.rd_req      = 1'b0;
    expect_grant(G_WR);
    step();
    bus.rd_done_all = 1'b0;
    step();
    want_second = 3'd3;
`else
    bus.wr_done_all = 1'b1;
    bus.wr_req      = 1'b0;
    expect_grant(G_RD);
    step();
    bus.wr_done_all = 1'b0;
    step();
    want_second = 3'd4;
`endif
    n_vec++;
    if (bus.arb_state !== want_second) begin
      n_err++;
      $display("FAIL tie_third: got state=%0d, want %0d", bus.arb_state, want_second);
    end
    step();
    bus.wr_done_all = 1'b1;
    bus.rd_done_all = 1'b1;
    bus.wr_req      = 1'b0;
    bus.rd_req      = 1'b0;
    step();
    bus.wr_done_all = 1'b0;
    bus.rd_done_all = 1'b0;
    n_vec++;
    if (bus.arb_state !== 3'd1) begin
      n_err++;
      $display("FAIL tie_end: got state=%0d, want 1", bus.arb_state);
    end
  endtask

  task automatic test_aref_yield();
    bus.rd_req = 1'b1;
    expect_grant(G_RD);
    step();
    step();
    bus.aref_req = 1'b1;
    step();
    n_vec++;
    if (bus.arb_state !== 3'd4) begin
      n_err++;
      $display("FAIL aref_no_preempt: got state=%0d, want 4", bus.arb_state);
    end
    bus.rd_go_aref = 1'b1;
    expect_grant(G_AREF);
    step();
    bus.rd_go_aref = 1'b0;
    n_vec++;
    if (bus.arb_state !== 3'd1 || bus.sdram_cmd !== NOP) begin
      n_err++;
      $display("FAIL yield_arb: got state=%0d cmd=%b, want 1 0111", bus.arb_state, bus.sdram_cmd);
    end
    step();
    n_vec++;
    if (bus.arb_state !== 3'd2) begin
      n_err++;
      $display("FAIL aref_state: got state=%0d, want 2", bus.arb_state);
    end
    bus.aref_done = 1'b1;
    bus.aref_req  = 1'b0;
    expect_grant(G_RD);
    step();
    bus.aref_done = 1'b0;
    step();
    n_vec++;
    if (bus.arb_state !== 3'd4) begin
      n_err++;
      $display("FAIL regrant_rd: got state=%0d, want 4", bus.arb_state);
    end
    step();
    bus.rd_done_all = 1'b1;
    bus.rd_req      = 1'b0;
    step();
    bus.rd_done_all = 1'b0;
  endtask

  task automatic test_starvation();
    bus.wr_req = 1'b1;
    expect_grant(G_WR);
    step();
    bus.aref_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_vec++;
      if (bus.aref_late !== (k >= 10) || bus.arb_state !== 3'd3) begin
        n_err++;
        $display("FAIL aref_late[%0d]: got late=%b state=%0d, want %b 3",
                 k, bus.aref_late, bus.arb_state, (k >= 10));
      end
    end
    bus.wr_go_aref = 1'b1;
    expect_grant(G_AREF);
    step();
    bus.wr_go_aref = 1'b0;
    step();
    n_vec++;
    if (bus.arb_state !== 3'd2 || bus.aref_late !== 1'b1) begin
      n_err++;
      $display("FAIL late_sticky: got state=%0d late=%b, want 2 1", bus.arb_state, bus.aref_late);
    end
    bus.aref_done = 1'b1;
    bus.aref_req  = 1'b0;
    expect_grant(G_WR);
    step();
    bus.aref_done = 1'b0;
    step();
    step();
    bus.wr_done_all = 1'b1;
    bus.wr_req      = 1'b0;
    step();
    bus.wr_done_all = 1'b0;
    n_vec++;
    if (bus.arb_state !== 3'd1 || bus.aref_late !== 1'b1) begin
      n_err++;
      $display("FAIL late_after: got state=%0d late=%b, want 1 1", bus.arb_state, bus.aref_late);
    end
  endtask

  task automatic test_bus_mux();
    bus.wr_req = 1'b1;
    expect_grant(G_WR);
    step();
    step();
    bus.wr_cmd  = 4'b0011;
    bus.wr_addr = 12'h3AA;
    bus.wr_ba   = 2'b10;
    #1;
    n_vec++;
    if (bus.sdram_cmd !== 4'b0011 || bus.sdram_addr !== 12'h3AA || bus.sdram_ba !== 2'b10) begin
      n_err++;
      $display("FAIL wr_mux: got cmd=%b addr=%h ba=%b, want 0011 3aa 10",
               bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba);
    end
    bus.rd_done_all = 1'b1;
    bus.rd_go_aref  = 1'b1;
    bus.aref_done   = 1'b1;
    step();
    bus.rd_done_all = 1'b0;
    bus.rd_go_aref  = 1'b0;
    bus.aref_done   = 1'b0;
    n_vec++;
    if (bus.arb_state !== 3'd3) begin
      n_err++;
      $display("FAIL stray_done: got state=%0d, want 3", bus.arb_state);
    end
    bus.wr_cmd      = 4'b0100;
    bus.wr_addr     = 12'h055;
    bus.wr_ba       = 2'b01;
    bus.wr_done_all = 1'b1;
    bus.wr_req      = 1'b0;
    step();
    bus.wr_done_all = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.rd_req = 1'b1;
    expect_grant(G_RD);
    step();
    n_vec++;
    if (bus.arb_state !== 3'd4) begin
      n_err++;
      $display("FAIL mid_read: got state=%0d, want 4", bus.arb_state);
    end
    sys_rst = 1'b1;
    step();
    sys_rst    = 1'b0;
    bus.rd_req = 1'b0;
    n_vec++;
    if (bus.arb_state !== 3'd0 || {bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b000 ||
        bus.aref_late !== 1'b0 || bus.sdram_cmd !== bus.init_cmd) begin
      n_err++;
      $display("FAIL reset_mid: got state=%0d grants=%b late=%b cmd=%b, want 0 000 0 %b",
               bus.arb_state, {bus.aref_en, bus.wr_en, bus.rd_en}, bus.aref_late,
               bus.sdram_cmd, bus.init_cmd);
    end
    step();
    n_vec++;
    if (bus.arb_state !== 3'd1) begin
      n_err++;
      $display("FAIL reinit: got state=%0d, want 1", bus.arb_state);
    end
  endtask

  initial begin
    bus.init_done   = 1'b0;
    bus.init_cmd    = 4'b0010;
    bus.init_addr   = 12'h400;
    bus.aref_req    = 1'b0;
    bus.aref_done   = 1'b0;
    bus.aref_cmd    = 4'b0001;
    bus.aref_addr   = 12'h123;
    bus.wr_req      = 1'b0;
    bus.wr_done_all = 1'b0;
    bus.wr_go_aref  = 1'b0;
    bus.wr_cmd      = 4'b0100;
    bus.wr_addr     = 12'h055;
    bus.wr_ba       = 2'b01;
    bus.rd_req      = 1'b0;
    bus.rd_done_all = 1'b0;
    bus.rd_go_aref  = 1'b0;
    bus.rd_cmd      = 4'b0101;
    bus.rd_addr     = 12'h0AA;
    bus.rd_ba       = 2'b10;

    test_reset();
    test_tie();
    test_aref_yield();
    test_starvation();
    test_bus_mux();
    test_reset_mid();
    step();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d grants outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
